// File: rtl/instr_fetch_unit.sv
// ifu_fifo: first-word-fall-through queue with synchronous flush, head visible while non-empty.
// Latency: a word pushed on an edge is at the head the following cycle.
// Backpressure: none internal; the owner's credit accounting guarantees no push when full.
module ifu_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push_vld,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic                       head_vld,
    output logic [WIDTH-1:0]           head_dat,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_pop;

    assign head_vld = (count != '0);
    assign head_dat = mem[rd_ptr];
    assign do_pop   = pop && head_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            if (push_vld && !do_pop) begin
                count <= count + 1'b1;
            end else if (!push_vld && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule

// instr_fetch_unit: owns the PC, reads a 1-cycle sync ROM, queues words for decode; redirect + halt at PC_LIMIT.
// Latency: request in cycle N -> instr_valid in cycle N+2; 1 instr/cycle while instr_ready is high.
// Backpressure: requests stop once queued + in-flight words would exceed FIFO_DEPTH; head holds while !instr_ready.
// Ports: clk/rst_n; imem_req/imem_addr/imem_rdata to the ROM; redirect_valid/redirect_pc restart fetch;
//        instr_valid/instr/instr_pc/instr_ready downstream handshake; halted when stopped and drained.
module instr_fetch_unit #(
    parameter int PC_WIDTH   = 5,
    parameter int DATA_WIDTH = 32,
    parameter int PC_LIMIT   = 7,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]   instr_pc,
    input  logic                  instr_ready,
    output logic                  halted
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = CW + 1;
    localparam logic [PC_WIDTH-1:0] LIMIT_PC = PC_WIDTH'(PC_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t              state;
    logic [PC_WIDTH-1:0] fetch_pc;
    logic [PC_WIDTH-1:0] tag_pc;
    logic                inflight;
    logic [CW-1:0]       count;
    logic                pop;
    logic                flush;
    logic                push;
    logic                issue;
    logic [SW-1:0]       occupancy;

    assign pop   = instr_valid && instr_ready;
    // IDLE ignores redirect, so only RUN/HALT flush.
    assign flush = redirect_valid && (state != IDLE);
    // The response of a request squashed by redirect is dropped here, never queued.
    assign push  = inflight && !flush;

    // Credits: slots already claimed by queued and in-flight words, minus the one leaving this cycle.
    assign occupancy = SW'(count) + SW'(inflight) - SW'(pop);
    assign issue     = (state == RUN) && !redirect_valid && (occupancy < SW'(FIFO_DEPTH));

    assign imem_req  = issue;
    assign imem_addr = fetch_pc;
    assign halted    = (state == HALT) && (count == '0) && !inflight;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= '0;
            tag_pc   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            case (state)
                IDLE: state <= RUN;
                RUN, HALT: begin
                    if (redirect_valid) begin
                        fetch_pc <= redirect_pc;
                        state    <= RUN;
                    end else if (issue) begin
                        tag_pc   <= fetch_pc;
                        fetch_pc <= fetch_pc + 1'b1;
                        if (fetch_pc == LIMIT_PC) begin
                            state <= HALT;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    ifu_fifo #(
        .WIDTH(PC_WIDTH + DATA_WIDTH),
        .DEPTH(FIFO_DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .push_vld(push),
        .push_dat({tag_pc, imem_rdata}),
        .pop     (instr_ready),
        .head_vld(instr_valid),
        .head_dat({instr_pc, instr}),
        .count   (count)
    );
endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
    localparam int PW    = 5;
    localparam int DW    = 32;
    localparam int LIMIT = 7;
    localparam int DEPTH = 2;
    localparam int NPC   = 1 << PW;
    localparam logic [PW-1:0] LIMIT_PC = PW'(LIMIT);

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          imem_req;
    logic [PW-1:0] imem_addr;
    logic [DW-1:0] imem_rdata;
    logic          redirect_valid;
    logic [PW-1:0] redirect_pc;
    logic          instr_valid;
    logic [DW-1:0] instr;
    logic [PW-1:0] instr_pc;
    logic          instr_ready;
    logic          halted;

    instr_fetch_unit #(
        .PC_WIDTH(PW), .DATA_WIDTH(DW), .PC_LIMIT(LIMIT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .halted(halted)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: one-cycle read latency.
    logic [DW-1:0] rom [NPC];
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= rom[imem_addr];
    end

    // Reference model: the program-order stream of PCs the consumer must see.
    int            n_asserts = 0;
    int            n_fail = 0;
    logic [PW-1:0] exp_pc;
    bit            exp_active;
    int            outstanding;
    bit            hold_vld;
    logic [PW-1:0] hold_pc;
    logic [DW-1:0] hold_instr;
    int            n_xfer;
    int            since_rst;
    int            base;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Observe one cycle at the negedge and advance the model.
    task automatic sample();
        @(negedge clk);
        since_rst++;
        if (hold_vld) begin
            check("hold_valid", 32'(instr_valid), 1);
            check("hold_pc", 32'(instr_pc), 32'(hold_pc));
            check("hold_instr", instr, hold_instr);
        end
        if (redirect_valid) check("req_blocked_by_redirect", 32'(imem_req), 0);
        if (instr_valid && instr_ready) begin
            if (!exp_active) begin
                check("xfer_after_limit", 32'(instr_valid), 0);
            end else begin
                check("xfer_pc", 32'(instr_pc), 32'(exp_pc));
                check("xfer_instr", instr, rom[exp_pc]);
                if (exp_pc == LIMIT_PC) exp_active = 0;
                exp_pc = exp_pc + 1'b1;
            end
            n_xfer++;
            outstanding--;
        end
        if (imem_req) begin
            outstanding++;
            check("credit_bound", 32'(outstanding <= DEPTH), 1);
        end
        hold_vld   = instr_valid && !instr_ready && !redirect_valid;
        hold_pc    = instr_pc;
        hold_instr = instr;
        if (redirect_valid && since_rst >= 2) begin
            exp_pc      = redirect_pc;
            exp_active  = 1;
            outstanding = 0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        #1;
        check("rst_instr_valid", 32'(instr_valid), 0);
        check("rst_imem_req", 32'(imem_req), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_instr", instr, 0);
        check("rst_instr_pc", 32'(instr_pc), 0);
        exp_pc = '0; exp_active = 1; outstanding = 0; hold_vld = 0; n_xfer = 0; since_rst = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_halted(input int budget, input string tag);
        int n;
        n = 0;
        sample();
        while (!halted && n < budget) begin
            adv();
            sample();
            n++;
        end
        check(tag, 32'(halted), 1);
        adv();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        for (int i = 0; i < NPC; i++) rom[i] = 32'h100 + i;
        #2;

        // Straight-line fetch of 0..7 then halt.
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            sample();
            check("t1_valid", 32'(instr_valid), 32'(k >= 4 && k <= 11));
            check("t1_req", 32'(imem_req), 32'(k >= 2 && k <= 9));
            check("t1_halted", 32'(halted), 32'(k >= 12));
            if (k >= 4 && k <= 11) check("t1_pc", 32'(instr_pc), 32'(k - 4));
            adv();
        end
        check("t1_count", n_xfer, 8);

        // Backpressure for 6 cycles starting with pc 2 at the head.
        do_reset();
        for (int k = 1; k <= 24; k++) begin
            instr_ready = !(k >= 6 && k <= 11);
            sample();
            if (k == 6) check("t2_head_pc", 32'(instr_pc), 2);
            if (k >= 7 && k <= 11) check("t2_req_dropped", 32'(imem_req), 0);
            if (k >= 12 && k <= 17) check("t2_no_gap", 32'(instr_valid), 1);
            adv();
        end
        wait_halted(20, "t2_halted");
        check("t2_count", n_xfer, 8);

        // Redirect to 5 while pc 2 is in flight (head pc 1 not taken).
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            instr_ready = (k != 5);
            redirect_valid = (k == 5);
            redirect_pc = 5'd5;
            sample();
            if (k == 5) check("t3_head_pc", 32'(instr_pc), 1);
            if (k == 6) check("t3_req", 32'(imem_req), 1);
            if (k == 6) check("t3_addr", 32'(imem_addr), 5);
            if (k == 6 || k == 7) check("t3_gap", 32'(instr_valid), 0);
            if (k == 8) check("t3_valid", 32'(instr_valid), 1);
            if (k == 8) check("t3_pc", 32'(instr_pc), 5);
            adv();
        end
        redirect_valid = 1'b0;
        instr_ready = 1'b1;
        wait_halted(20, "t3_halted");
        check("t3_count", n_xfer, 4);

        // Redirect to 0 in the same cycle pc 1 is transferred.
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            redirect_valid = (k == 5);
            redirect_pc = 5'd0;
            sample();
            if (k == 5) check("t4_head_pc", 32'(instr_pc), 1);
            if (k == 6 || k == 7) check("t4_no_stale", 32'(instr_valid), 0);
            if (k == 8) check("t4_pc", 32'(instr_pc), 0);
            adv();
        end
        redirect_valid = 1'b0;
        wait_halted(20, "t4_halted");
        check("t4_count", n_xfer, 10);

        // Redirect to 3 while halted.
        base = n_xfer;
        redirect_valid = 1'b1;
        redirect_pc = 5'd3;
        sample();
        check("t5_halted_before", 32'(halted), 1);
        adv();
        redirect_valid = 1'b0;
        sample();
        check("t5_halted_fell", 32'(halted), 0);
        adv();
        wait_halted(30, "t5_halted_again");
        check("t5_count", n_xfer - base, 5);

        // Reset with one word queued and one in flight.
        instr_ready = 1'b0;
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            sample();
            if (k == 4) check("t6_queued", 32'(instr_valid), 1);
            if (k < 4) adv();
        end
        do_reset();
        instr_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            sample();
            if (k == 4) check("t6_restart_pc", 32'(instr_pc), 0);
            adv();
        end
        wait_halted(20, "t6_halted");
        check("t6_count", n_xfer, 8);

        // Randomized ready/redirect against the stream model.
        for (int i = 0; i < NPC; i++) rom[i] = $urandom;
        do_reset();
        for (int k = 1; k <= 400; k++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = (k >= 2) && ($urandom_range(0, 15) == 0);
            redirect_pc = PW'($urandom_range(0, NPC - 1));
            sample();
            adv();
        end
        redirect_valid = 1'b0;
        instr_ready = 1'b1;
        wait_halted(80, "rand_final_halt");
        check("rand_all_delivered", 32'(exp_active), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
